// File: rtl/stim_sequencer_pkg.sv
// Shared constants, FSM state type and sizing helper for stim_sequencer.
// Optional feature macro: STIM_PAUSE_EN (adds the pause input).
package stim_pkg;

    localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC = 32'h3039;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_RUN,
        ST_FIN
    } stim_state_e;

    // Number of 32-bit LCG words needed to fill a w-bit vector.
    function automatic int nw_of(input int w);
        return (w + 31) / 32;
    endfunction

endpackage

// File: rtl/stim_sequencer_if.sv
// Control/stimulus bundle between a test controller and stim_sequencer.
// Optional feature macro: STIM_PAUSE_EN (adds pause).
interface stim_if #(
    parameter int IN_W = 134
);
    logic            start;
    logic [31:0]     cycles;
    logic            stop;
    logic            seed_load;
    logic [31:0]     seed;
`ifdef STIM_PAUSE_EN
    logic            pause;
`endif
    logic            dut_rst_n;
    logic [IN_W-1:0] in_flat;
    logic            busy;
    logic            done;
    logic [31:0]     cyc_cnt;

`ifdef STIM_PAUSE_EN
    modport master (
        output start, cycles, stop, seed_load, seed, pause,
        input  dut_rst_n, in_flat, busy, done, cyc_cnt
    );
    modport slave (
        input  start, cycles, stop, seed_load, seed, pause,
        output dut_rst_n, in_flat, busy, done, cyc_cnt
    );
`else
    modport master (
        output start, cycles, stop, seed_load, seed,
        input  dut_rst_n, in_flat, busy, done, cyc_cnt
    );
    modport slave (
        input  start, cycles, stop, seed_load, seed,
        output dut_rst_n, in_flat, busy, done, cyc_cnt
    );
`endif

endinterface

// File: rtl/lcg_step.sv
// One combinational LCG step: s' = s * LCG_MUL + LCG_INC (mod 2^32).
// Optional feature macro: none.
module lcg_step
    import stim_pkg::*;
(
    input  logic [31:0] s_in,
    output logic [31:0] s_out
);

    assign s_out = s_in * LCG_MUL + LCG_INC;

endmodule

// File: rtl/stim_sequencer.sv
// LCG-driven stimulus sequencer with DUT reset hold and run control.
// Optional feature macro: STIM_PAUSE_EN (pause freezes a run in RUN).
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int          IN_W       = 134,
    parameter int          RST_CYCLES = 2,
    parameter logic [31:0] DEF_SEED   = 32'd2320500417
) (
    input  logic clk,
    input  logic rst,
    stim_if.slave bus
);

    localparam int NW = nw_of(IN_W);

    stim_state_e     state_q, state_d;
    logic [31:0]     lcg_q, lcg_d;
    logic [31:0]     cycles_q, cycles_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     hold_q, hold_d;
    logic [IN_W-1:0] flat_q, flat_d;
    logic            rstn_q, rstn_d;

    logic [31:0]     base;
    logic [31:0]     words [NW];
    logic [IN_W-1:0] vec;
    logic            adv;
    logic            last;

    // A seed loaded together with start feeds vector 0 directly.
    assign base = (state_q == ST_IDLE && bus.seed_load) ? bus.seed : lcg_q;

    for (genvar k = 0; k < NW; k++) begin : g_chain
        localparam int WW = (IN_W - 32 * k) >= 32 ? 32 : IN_W - 32 * k;
        if (k == 0) begin : g_first
            lcg_step u_step (.s_in(base), .s_out(words[k]));
        end else begin : g_next
            lcg_step u_step (.s_in(words[k-1]), .s_out(words[k]));
        end
        assign vec[32*k +: WW] = words[k][WW-1:0];
    end

`ifdef STIM_PAUSE_EN
    assign adv = !bus.pause;
`else
    assign adv = 1'b1;
`endif

    assign last = (cnt_q + 32'd1) == cycles_q;

    // Next-state and datapath update decisions.
    always_comb begin
        state_d  = state_q;
        lcg_d    = lcg_q;
        cycles_d = cycles_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        flat_d   = flat_q;
        rstn_d   = rstn_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.seed_load) lcg_d = bus.seed;
                if (bus.start) begin
                    cycles_d = bus.cycles;
                    flat_d   = vec;
                    lcg_d    = words[NW-1];
                    cnt_d    = 32'd0;
                    hold_d   = 32'd0;
                    rstn_d   = 1'b0;
                    state_d  = ST_RST_HOLD;
                end
            end
            ST_RST_HOLD: begin
                if (hold_q + 32'd1 >= 32'(RST_CYCLES)) begin
                    rstn_d  = 1'b1;
                    state_d = (cycles_q == 32'd0) ? ST_FIN : ST_RUN;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            ST_RUN: begin
                // A stop landing on the final update still completes it.
                if (adv && (!bus.stop || last)) begin
                    flat_d = vec;
                    lcg_d  = words[NW-1];
                    cnt_d  = cnt_q + 32'd1;
                end
                if (bus.stop) state_d = ST_IDLE;
                else if (adv && last) state_d = ST_FIN;
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lcg_q    <= DEF_SEED;
            cycles_q <= 32'd0;
            cnt_q    <= 32'd0;
            hold_q   <= 32'd0;
            flat_q   <= '0;
            rstn_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lcg_q    <= lcg_d;
            cycles_q <= cycles_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            flat_q   <= flat_d;
            rstn_q   <= rstn_d;
        end
    end

    assign bus.dut_rst_n = rstn_q;
    assign bus.in_flat   = flat_q;
    assign bus.busy      = state_q != ST_IDLE;
    assign bus.done      = state_q == ST_FIN;
    assign bus.cyc_cnt   = cnt_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed self-checking bench for stim_sequencer.
// Optional feature macro: STIM_PAUSE_EN (enables the pause scenario).
module tb_stim_sequencer;

    localparam int          IN_W = 134;
    localparam logic [31:0] DEF  = 32'd2320500417;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nt  = 0;
    int   nf  = 0;
    logic [31:0] m_s;

    always #5 clk = ~clk;

    stim_if #(.IN_W(IN_W)) bus ();

    stim_sequencer #(
        .IN_W(IN_W),
        .RST_CYCLES(2),
        .DEF_SEED(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] step(input logic [31:0] s);
        return s * 32'h41C64E6D + 32'h3039;
    endfunction

    function automatic logic [31:0] adv5(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 5; k++) t = step(t);
        return t;
    endfunction

    function automatic logic [IN_W-1:0] mkvec(input logic [31:0] s);
        logic [159:0] f;
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 5; k++) begin
            t = step(t);
            f[32*k +: 32] = t;
        end
        return f[IN_W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int dones);
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            if (!bus.busy) break;
            tick();
            if (bus.done) dones++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        nt++; if (bus.busy !== 1'b0) begin nf++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        nt++; if (bus.done !== 1'b0) begin nf++; $display("FAIL rst_done: got %b want 0", bus.done); end
        nt++; if (bus.dut_rst_n !== 1'b0) begin nf++; $display("FAIL rst_dut_rst_n: got %b want 0", bus.dut_rst_n); end
        nt++; if (bus.in_flat !== '0) begin nf++; $display("FAIL rst_in_flat: got %h want 0", bus.in_flat); end
        nt++; if (bus.cyc_cnt !== 32'd0) begin nf++; $display("FAIL rst_cyc_cnt: got %h want 0", bus.cyc_cnt); end
        rst = 1'b0;
        m_s = DEF;
    endtask

    task automatic test_default_seed();
        int d;
        bus.cycles = 32'd0;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        nt++; if (bus.in_flat !== mkvec(m_s)) begin nf++; $display("FAIL def_seed_vec: got %h want %h", bus.in_flat, mkvec(m_s)); end
        nt++; if (bus.busy !== 1'b1 || bus.dut_rst_n !== 1'b0) begin nf++; $display("FAIL def_seed_hold: got busy=%b rst_n=%b want 1 0", bus.busy, bus.dut_rst_n); end
        m_s = adv5(m_s);
        wait_idle(d);
        nt++; if (bus.busy !== 1'b0) begin nf++; $display("FAIL def_seed_timeout: got busy=%b want 0", bus.busy); end
        nt++; if (d !== 1) begin nf++; $display("FAIL def_seed_done: got %0d want 1", d); end
    endtask

    task automatic test_seed_zero();
        int k;
        logic [31:0] w0;
        bus.seed_load = 1'b1;
        bus.seed      = 32'd0;
        tick();
        bus.seed_load = 1'b0;
        nt++; if (bus.busy !== 1'b0) begin nf++; $display("FAIL seed0_busy: got %b want 0", bus.busy); end
        bus.cycles = 32'd0;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        k = 1;
        w0 = bus.in_flat[31:0];
        nt++; if (w0 !== 32'h00003039) begin nf++; $display("FAIL seed0_word0: got %h want 00003039", w0); end
        nt++; if (bus.in_flat !== mkvec(32'd0)) begin nf++; $display("FAIL seed0_vec: got %h want %h", bus.in_flat, mkvec(32'd0)); end
        m_s = adv5(32'd0);
        while (!bus.done && k < 10) begin
            tick();
            k++;
        end
        nt++; if (k !== 3) begin nf++; $display("FAIL seed0_done_lat: got %0d want 3", k); end
        tick();
        nt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin nf++; $display("FAIL seed0_end: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    endtask

    task automatic test_seed_one_run();
        logic [IN_W-1:0] v0;
        logic [31:0] w0, pc;
        int t, dones, dt, bt, upd;
        bus.seed_load = 1'b1;
        bus.seed      = 32'd1;
        bus.cycles    = 32'd3;
        bus.start     = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        bus.start     = 1'b0;
        w0 = bus.in_flat[31:0];
        nt++; if (w0 !== 32'h41C67EA6) begin nf++; $display("FAIL seed1_word0: got %h want 41c67ea6", w0); end
        nt++; if (bus.in_flat !== mkvec(32'd1)) begin nf++; $display("FAIL seed1_vec: got %h want %h", bus.in_flat, mkvec(32'd1)); end
        m_s = adv5(32'd1);
        v0 = bus.in_flat;
        tick();
        nt++; if (bus.dut_rst_n !== 1'b0 || bus.in_flat !== v0) begin nf++; $display("FAIL hold1: got rst_n=%b flat=%h want 0 %h", bus.dut_rst_n, bus.in_flat, v0); end
        tick();
        nt++; if (bus.dut_rst_n !== 1'b1 || bus.in_flat !== v0) begin nf++; $display("FAIL hold_exit: got rst_n=%b flat=%h want 1 %h", bus.dut_rst_n, bus.in_flat, v0); end
        t = 0; dones = 0; dt = -1; bt = -1; upd = 0; pc = bus.cyc_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            t++;
            if (bus.done) begin dones++; dt = t; end
            if (bus.cyc_cnt !== pc) begin
                upd++;
                nt++; if (bus.in_flat !== mkvec(m_s)) begin nf++; $display("FAIL run_vec%0d: got %h want %h", upd, bus.in_flat, mkvec(m_s)); end
                m_s = adv5(m_s);
                pc = bus.cyc_cnt;
            end
            if (!bus.busy) begin bt = t; break; end
        end
        nt++; if (upd !== 3) begin nf++; $display("FAIL run_updates: got %0d want 3", upd); end
        nt++; if (bus.cyc_cnt !== 32'd3) begin nf++; $display("FAIL run_cyc_cnt: got %0d want 3", bus.cyc_cnt); end
        nt++; if (dones !== 1) begin nf++; $display("FAIL run_dones: got %0d want 1", dones); end
        nt++; if (bt !== dt + 1 || bt < 0) begin nf++; $display("FAIL run_busy_fall: got %0d want %0d", bt, dt + 1); end
    endtask

    task automatic test_stop();
        logic [IN_W-1:0] ex;
        int d;
        bus.cycles = 32'd10;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        nt++; if (bus.in_flat !== mkvec(m_s)) begin nf++; $display("FAIL stop_v0: got %h want %h", bus.in_flat, mkvec(m_s)); end
        m_s = adv5(m_s);
        tick();
        tick();
        ex = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ex = mkvec(m_s);
            m_s = adv5(m_s);
        end
        nt++; if (bus.cyc_cnt !== 32'd4 || bus.in_flat !== ex) begin nf++; $display("FAIL stop_pre: got cnt=%0d flat=%h want 4 %h", bus.cyc_cnt, bus.in_flat, ex); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        nt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin nf++; $display("FAIL stop_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        nt++; if (bus.cyc_cnt !== 32'd4 || bus.in_flat !== ex) begin nf++; $display("FAIL stop_freeze: got cnt=%0d flat=%h want 4 %h", bus.cyc_cnt, bus.in_flat, ex); end
        d = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done) d++;
        end
        nt++; if (d !== 0) begin nf++; $display("FAIL stop_no_done: got %0d want 0", d); end
        bus.cycles = 32'd1;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        nt++; if (bus.in_flat !== mkvec(m_s)) begin nf++; $display("FAIL restart_v0: got %h want %h", bus.in_flat, mkvec(m_s)); end
        m_s = adv5(m_s);
        ex = mkvec(m_s);
        m_s = adv5(m_s);
        wait_idle(d);
        nt++; if (bus.busy !== 1'b0 || d !== 1) begin nf++; $display("FAIL restart_end: got busy=%b dones=%0d want 0 1", bus.busy, d); end
        nt++; if (bus.in_flat !== ex || bus.cyc_cnt !== 32'd1) begin nf++; $display("FAIL restart_vec: got cnt=%0d flat=%h want 1 %h", bus.cyc_cnt, bus.in_flat, ex); end
    endtask

    task automatic test_stop_final();
        logic [IN_W-1:0] ex;
        bus.cycles = 32'd2;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        m_s = adv5(m_s);
        tick();
        tick();
        tick();
        m_s = adv5(m_s);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        ex = mkvec(m_s);
        m_s = adv5(m_s);
        nt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin nf++; $display("FAIL stopfin_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        nt++; if (bus.cyc_cnt !== 32'd2 || bus.in_flat !== ex) begin nf++; $display("FAIL stopfin_cnt: got cnt=%0d flat=%h want 2 %h", bus.cyc_cnt, bus.in_flat, ex); end
        tick();
        nt++; if (bus.done !== 1'b0) begin nf++; $display("FAIL stopfin_late_done: got %b want 0", bus.done); end
    endtask

    task automatic test_ignored();
        logic [IN_W-1:0] ex;
        int d;
        bus.cycles = 32'd10;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        m_s = adv5(m_s);
        tick();
        tick();
        tick();
        m_s = adv5(m_s);
        bus.start     = 1'b1;
        bus.seed_load = 1'b1;
        bus.seed      = 32'd0;
        bus.cycles    = 32'd3;
        tick();
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        ex = mkvec(m_s);
        m_s = adv5(m_s);
        nt++; if (bus.in_flat !== ex || bus.cyc_cnt !== 32'd2) begin nf++; $display("FAIL ign_vec: got cnt=%0d flat=%h want 2 %h", bus.cyc_cnt, bus.in_flat, ex); end
        nt++; if (bus.busy !== 1'b1) begin nf++; $display("FAIL ign_busy: got %b want 1", bus.busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            ex = mkvec(m_s);
            m_s = adv5(m_s);
        end
        nt++; if (bus.cyc_cnt !== 32'd5 || bus.in_flat !== ex) begin nf++; $display("FAIL ign_cnt5: got cnt=%0d flat=%h want 5 %h", bus.cyc_cnt, bus.in_flat, ex); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_s = DEF;
        nt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dut_rst_n !== 1'b0) begin nf++; $display("FAIL midrst_ctl: got busy=%b done=%b rst_n=%b want 0 0 0", bus.busy, bus.done, bus.dut_rst_n); end
        nt++; if (bus.in_flat !== '0 || bus.cyc_cnt !== 32'd0) begin nf++; $display("FAIL midrst_data: got cnt=%0d flat=%h want 0 0", bus.cyc_cnt, bus.in_flat); end
        tick();
        tick();
        nt++; if (bus.dut_rst_n !== 1'b0 || bus.done !== 1'b0) begin nf++; $display("FAIL midrst_after: got rst_n=%b done=%b want 0 0", bus.dut_rst_n, bus.done); end
        bus.cycles = 32'd0;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        nt++; if (bus.in_flat !== mkvec(DEF)) begin nf++; $display("FAIL midrst_seed: got %h want %h", bus.in_flat, mkvec(DEF)); end
        m_s = adv5(m_s);
        wait_idle(d);
        nt++; if (bus.busy !== 1'b0) begin nf++; $display("FAIL midrst_timeout: got busy=%b want 0", bus.busy); end
    endtask

`ifdef STIM_PAUSE_EN
    task automatic test_pause();
        logic [IN_W-1:0] ex;
        int d;
        bus.cycles = 32'd4;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        m_s = adv5(m_s);
        tick();
        tick();
        tick();
        ex = mkvec(m_s);
        m_s = adv5(m_s);
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nt++; if (bus.cyc_cnt !== 32'd1 || bus.in_flat !== ex) begin nf++; $display("FAIL pause%0d: got cnt=%0d flat=%h want 1 %h", i, bus.cyc_cnt, bus.in_flat, ex); end
        end
        bus.pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex = mkvec(m_s);
            m_s = adv5(m_s);
        end
        wait_idle(d);
        nt++; if (bus.busy !== 1'b0 || d !== 1) begin nf++; $display("FAIL pause_end: got busy=%b dones=%0d want 0 1", bus.busy, d); end
        nt++; if (bus.cyc_cnt !== 32'd4 || bus.in_flat !== ex) begin nf++; $display("FAIL pause_total: got cnt=%0d flat=%h want 4 %h", bus.cyc_cnt, bus.in_flat, ex); end
    endtask
`endif

    initial begin
        bus.start     = 1'b0;
        bus.cycles    = 32'd0;
        bus.stop      = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed      = 32'd0;
`ifdef STIM_PAUSE_EN
        bus.pause     = 1'b0;
`endif
        m_s = DEF;
        test_reset();
        test_default_seed();
        test_seed_zero();
        test_seed_one_run();
        test_stop();
        test_stop_final();
        test_ignored();
`ifdef STIM_PAUSE_EN
        test_pause();
`endif
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
